// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated 4-bit ALU slice:
// opcodes, datapath width and the arbiter FSM states.
package alu_pkg;

    localparam int DATA_W = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_MAX = 3'b110;
    localparam logic [2:0] OP_EQU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

endpackage

// File: rtl/alu_top.sv
// Combinational 4-bit ALU. Flags are raw here; the arbiter
// masks them by opcode. MAX/EQU compare unsigned operands.
module alu_top
    import alu_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              overflow,
    output logic              max,
    output logic              equ
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        diff     = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        max      = (a > b);
        equ      = (a == b);
        unique case (op)
            OP_ADD: begin
                result   = sum[DATA_W-1:0];
                carry    = sum[DATA_W];
                overflow = (a[DATA_W-1] == b[DATA_W-1]) &&
                           (sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                result   = diff[DATA_W-1:0];
                carry    = diff[DATA_W];
                overflow = (a[DATA_W-1] != b[DATA_W-1]) &&
                           (diff[DATA_W-1] != a[DATA_W-1]);
            end
            OP_NOT: result = ~a;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            // result is the larger operand; EQU leaves a^b (zero iff equal)
            OP_MAX: result = (a > b) ? a : b;
            OP_EQU: result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters,
// with a registered response channel and per-requester counters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [2:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [2:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_carry,
    output logic              rsp_overflow,
    output logic              rsp_max,
    output logic              rsp_equ,
    output logic              rsp_zero,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    state_t            state;
    state_t            state_nxt;
    logic              last;
    logic              grant0;
    logic              grant1;
    logic              take;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              id_q;

    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_o;
    logic              alu_m;
    logic              alu_e;
    logic              arith;
    logic              ov_m;
    logic [DATA_W-1:0] res_m;

    alu_top u_alu (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .result   (alu_res),
        .carry    (alu_c),
        .overflow (alu_o),
        .max      (alu_m),
        .equ      (alu_e)
    );

    assign arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign ov_m  = arith && alu_o;
    assign res_m = ov_m ? '0 : alu_res;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (take) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_RESP;
            S_RESP:  if (rsp_valid && rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // On conflict the requester that was not served last wins
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == S_IDLE && !rst) begin
            grant0 = req0_valid && (!req1_valid || last);
            grant1 = req1_valid && (!req0_valid || !last);
        end
        req0_ready = grant0;
        req1_ready = grant1;
        take       = grant0 || grant1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_max      <= 1'b0;
            rsp_equ      <= 1'b0;
            rsp_zero     <= 1'b0;
            last         <= 1'b1;
            cnt0         <= '0;
            cnt1         <= '0;
        end else begin
            if (take) begin
                id_q <= grant1;
                op_q <= grant1 ? req1_op : req0_op;
                a_q  <= grant1 ? req1_a  : req0_a;
                b_q  <= grant1 ? req1_b  : req0_b;
            end
            if (state == S_EXEC) begin
                rsp_valid    <= 1'b1;
                rsp_id       <= id_q;
                rsp_result   <= res_m;
                rsp_carry    <= arith && alu_c;
                rsp_overflow <= ov_m;
                rsp_max      <= (op_q == OP_MAX) && alu_m;
                rsp_equ      <= (op_q == OP_EQU) && alu_e;
                rsp_zero     <= (res_m == '0);
            end
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
                last      <= rsp_id;
                if (rsp_id) cnt1 <= cnt1 + 1'b1;
                else        cnt0 <= cnt0 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: single ops, conflicts,
// back-pressure, reset mid-operation and counter wrap.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready;
    logic [2:0] req0_op;
    logic [3:0] req0_a, req0_b;
    logic       req1_valid, req1_ready;
    logic [2:0] req1_op;
    logic [3:0] req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [3:0] rsp_result;
    logic       rsp_carry, rsp_overflow, rsp_max, rsp_equ, rsp_zero;
    logic [7:0] cnt0, cnt1;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int e0     = 0;
    int e1     = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_op      (req0_op),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_op      (req1_op),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_carry    (rsp_carry),
        .rsp_overflow (rsp_overflow),
        .rsp_max      (rsp_max),
        .rsp_equ      (rsp_equ),
        .rsp_zero     (rsp_zero),
        .cnt0         (cnt0),
        .cnt1         (cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic id, input logic [2:0] op,
                          input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] r, input logic c,
                          input logic o, input logic z,
                          input logic m, input logic e);
        @(negedge clk);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        #1 chk("ready", id ? req1_ready : req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1 chk("exec_no_valid", rsp_valid, 0);
        @(negedge clk);
        #1;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, id);
        chk("rsp_result", rsp_result, r);
        chk("rsp_carry", rsp_carry, c);
        chk("rsp_overflow", rsp_overflow, o);
        chk("rsp_zero", rsp_zero, z);
        chk("rsp_max", rsp_max, m);
        chk("rsp_equ", rsp_equ, e);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (id) e1++;
        else    e0++;
        #1 chk("rsp_cleared", rsp_valid, 0);
        chk("cnt0", cnt0, e0);
        chk("cnt1", cnt1, e1);
    endtask

    initial begin
        int gi[8];
        int gid[8];
        int rid[8];
        int ng;
        int nr;

        rst = 1'b1;
        req0_valid = 1'b0; req0_op = 3'd0; req0_a = 4'd0; req0_b = 4'd0;
        req1_valid = 1'b0; req1_op = 3'd0; req1_a = 4'd0; req1_b = 4'd0;
        rsp_ready = 1'b0;

        @(negedge clk);
        req0_valid = 1'b1;
        #1;
        chk("reset_ready0", req0_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_result", rsp_result, 0);
        chk("reset_cnt0", cnt0, 0);
        chk("reset_cnt1", cnt1, 0);
        req0_valid = 1'b0;
        rst = 1'b0;

        // id, op, a, b, result, carry, ovf, zero, max, equ
        run_op(0, 3'b000, 4'h3, 4'h4, 4'h7, 0, 0, 0, 0, 0);
        run_op(1, 3'b000, 4'h7, 4'h1, 4'h0, 0, 1, 1, 0, 0);
        run_op(0, 3'b001, 4'h5, 4'h3, 4'h2, 1, 0, 0, 0, 0);
        run_op(0, 3'b011, 4'hC, 4'hA, 4'h8, 0, 0, 0, 0, 0);
        run_op(1, 3'b110, 4'h6, 4'h2, 4'h6, 0, 0, 0, 1, 0);
        run_op(0, 3'b111, 4'h5, 4'h5, 4'h0, 0, 0, 1, 0, 1);

        // Conflict: both requesters valid right after reset
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e0 = 0;
        e1 = 0;
        req0_op = 3'b000; req0_a = 4'h1; req0_b = 4'h1;
        req1_op = 3'b000; req1_a = 4'h2; req1_b = 4'h2;
        rsp_ready = 1'b1;
        ng = 0;
        nr = 0;
        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk);
            req0_valid = (ng < 4);
            req1_valid = (ng < 4);
            #1;
            if (rsp_valid && nr < 8) begin
                rid[nr] = int'(rsp_id);
                nr++;
            end
            if ((req0_ready || req1_ready) && ng < 8) begin
                gi[ng]  = i;
                gid[ng] = int'(req1_ready);
                ng++;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        chk("conflict_ngrant", ng, 4);
        chk("conflict_nrsp", nr, 4);
        for (int k = 0; k < 4; k++) begin
            chk("conflict_grant_id", gid[k], k % 2);
            chk("conflict_rsp_id", rid[k], k % 2);
            if (k > 0) chk("conflict_interval", gi[k] - gi[k-1], 3);
        end
        e0 = 2;
        e1 = 2;
        chk("conflict_cnt0", cnt0, e0);
        chk("conflict_cnt1", cnt1, e1);

        // Back-pressure: response held while a new request waits
        @(negedge clk);
        req1_valid = 1'b1; req1_op = 3'b100; req1_a = 4'h5; req1_b = 4'hA;
        #1 chk("bp_ready1", req1_ready, 1);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 4'h1; req0_b = 4'h1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_result", rsp_result, 4'hF);
            chk("bp_id", rsp_id, 1);
            chk("bp_no_ready", req0_ready, 0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1 chk("bp_same_cycle_ready", req0_ready, 0);
        @(negedge clk);
        rsp_ready = 1'b0;
        e1++;
        #1;
        chk("bp_released", rsp_valid, 0);
        chk("bp_cnt1", cnt1, e1);
        chk("bp_idle_ready", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("bp_next_result", rsp_result, 4'h2);
        chk("bp_next_id", rsp_id, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        e0++;
        #1 chk("bp_cnt0", cnt0, e0);

        // Reset while the ALU is in EXEC
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 4'h3; req0_b = 4'h3;
        #1 chk("rx_ready", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("rx_rsp_valid", rsp_valid, 0);
        chk("rx_cnt0", cnt0, 0);
        chk("rx_cnt1", cnt1, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("rx_no_rsp", rsp_valid, 0);
        chk("rx_cnt0_still", cnt0, 0);

        // Counter wrap: 256 back-to-back requester 0 completions
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 4'h1; req0_b = 4'h1;
        rsp_ready = 1'b1;
        repeat (765) @(negedge clk);
        #1 chk("wrap_cnt0_255", cnt0, 8'd255);
        repeat (3) @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("wrap_cnt0_0", cnt0, 0);
        chk("wrap_cnt1", cnt1, 0);
        rsp_ready = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
